// File: rtl/clic_reg_master_pkg.sv
// Shared CLIC definitions: configuration-op encoding, register offsets and
// the register-bus request/response structs.
package clic_reg_master_pkg;

    typedef enum logic [1:0] {
        CFG_READ  = 2'd0,
        CFG_WRITE = 2'd1,
        CFG_RMW   = 2'd2
    } cfg_op_e;

    localparam logic [12:0] CLIC_CFG_OFFSET     = 13'h0000;
    localparam logic [12:0] CLIC_INFO_OFFSET    = 13'h0004;
    localparam logic [12:0] CLIC_INT_BASE       = 13'h1000;
    localparam logic [12:0] CLIC_INT_STRIDE     = 13'h0004;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clic_reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } clic_reg_rsp_t;

    // Mask bit 1 takes the new bit, 0 keeps the bit that was read.
    function automatic logic [31:0] rmw_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/clic_reg_master.sv
// Register-bus initiator issuing single READ / WRITE / RMW accesses to the
// CLIC register file, with a per-phase ready timeout.
module clic_reg_master
    import clic_reg_master_pkg::*;
#(
    parameter type reg_req_t     = clic_reg_req_t,
    parameter type reg_rsp_t     = clic_reg_rsp_t,
    parameter int  AW            = 13,
    parameter int  TimeoutCycles = 256
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [31:0]   cmd_wdata_i,
    input  logic [31:0]   cmd_mask_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_error_o,
    output logic          rsp_timeout_o,
    output logic          busy_o,
    output reg_req_t      reg_req_o,
    input  reg_rsp_t      reg_rsp_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    localparam int CNT_W = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TimeoutCycles - 1);

    state_e           state_q, state_d;
    cfg_op_e          op_q, op_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      mask_q, mask_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             error_q, error_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
    reg_req_t         req;

    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CNT_LIM);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    op_d      = cfg_op_e'(cmd_op_i);
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    mask_d    = cmd_mask_i;
                    rdata_d   = '0;
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    case (cmd_op_i)
                        CFG_READ, CFG_RMW: state_d = RD;
                        CFG_WRITE:         state_d = WR;
                        default: begin
                            error_d = 1'b1;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            RD: begin
                // A ready coinciding with the threshold completes normally.
                if (reg_rsp_i.ready) begin
                    rdata_d = reg_rsp_i.rdata;
                    error_d = reg_rsp_i.error;
                    if (op_q == CFG_RMW && !reg_rsp_i.error) begin
                        wdata_d = rmw_merge(reg_rsp_i.rdata, wdata_q, mask_q);
                        cnt_d   = '0;
                        state_d = WR;
                    end else begin
                        state_d = RESP;
                    end
                end else if (timeout_hit) begin
                    rdata_d   = '0;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR: begin
                if (reg_rsp_i.ready) begin
                    error_d = reg_rsp_i.error;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d   = '0;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= CFG_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Request is decoded from registered state only, so no input reaches it combinationally.
    always_comb begin
        req = '0;
        if (state_q == RD || state_q == WR) begin
            req.valid          = 1'b1;
            req.addr[AW-1:0]   = addr_q;
            if (state_q == WR) begin
                req.write = 1'b1;
                req.wdata = wdata_q;
                req.wstrb = 4'hF;
            end
        end
    end

    assign reg_req_o     = req;
    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rsp_valid_o ? rdata_q : '0;
    assign rsp_error_o   = rsp_valid_o & error_q;
    assign rsp_timeout_o = rsp_valid_o & timeout_q;

endmodule

// File: tb/tb_clic_reg_master.sv
// Directed bench for clic_reg_master: basic ops, RMW merge, error, timeout,
// response back-pressure and reset in the middle of an access.
module tb_clic_reg_master;
    import clic_reg_master_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [12:0]   cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [31:0]   cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          busy;
    clic_reg_req_t req;
    clic_reg_rsp_t rsp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clic_reg_master #(.AW(13), .TimeoutCycles(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_mask_i   (cmd_mask),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_error_o  (rsp_error),
        .rsp_timeout_o(rsp_timeout),
        .busy_o       (busy),
        .reg_req_o    (req),
        .reg_rsp_i    (rsp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command in the current cycle (N) and returns in cycle N+1.
    task automatic send(input logic [1:0] op, input logic [12:0] addr,
                        input logic [31:0] wd, input logic [31:0] mk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_mask  = mk;
        chk("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp = '0;
        rsp.ready = 1'b1;
        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_req",       32'(req.valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_rdata",     rsp_rdata,      32'd0);

        // READ 0x0000 -> 0x2A
        rsp.rdata = 32'h2A;
        send(2'd0, 13'h0000, 32'h0, 32'h0);
        chk("rd_req_valid", 32'(req.valid), 32'd1);
        chk("rd_req_write", 32'(req.write), 32'd0);
        chk("rd_req_addr",  req.addr,       32'h0000);
        chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata,      32'h2A);
        chk("rd_rsp_error", 32'(rsp_error), 32'd0);
        tick();

        // WRITE 0x1008 <- 0xC3
        send(2'd1, 13'h1008, 32'hC3, 32'h0);
        chk("wr_req_valid", 32'(req.valid), 32'd1);
        chk("wr_req_write", 32'(req.write), 32'd1);
        chk("wr_req_wstrb", 32'(req.wstrb), 32'hF);
        chk("wr_req_wdata", req.wdata,      32'hC3);
        chk("wr_req_addr",  req.addr,       32'h1008);
        tick();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_rdata", rsp_rdata,      32'd0);
        chk("wr_rsp_error", 32'(rsp_error), 32'd0);
        tick();

        // RMW 0x100C, mask 0xF0, wdata 0x50, read 0xA5 -> write 0x55
        rsp.rdata = 32'hA5;
        send(2'd2, 13'h100C, 32'h50, 32'hF0);
        chk("rmw_rd_write", 32'(req.write), 32'd0);
        chk("rmw_rd_addr",  req.addr,       32'h100C);
        tick();
        chk("rmw_wr_valid", 32'(req.valid), 32'd1);
        chk("rmw_wr_write", 32'(req.write), 32'd1);
        chk("rmw_wr_wdata", req.wdata,      32'h55);
        chk("rmw_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("rmw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rmw_rsp_rdata", rsp_rdata,      32'hA5);
        chk("rmw_rsp_error", 32'(rsp_error), 32'd0);
        tick();

        // RMW whose read errors: write phase skipped
        rsp.rdata = 32'h77;
        rsp.error = 1'b1;
        send(2'd2, 13'h1010, 32'hFF, 32'hFF);
        chk("rmwerr_rd_valid", 32'(req.valid), 32'd1);
        tick();
        rsp.error = 1'b0;
        chk("rmwerr_no_write", 32'(req.valid),   32'd0);
        chk("rmwerr_rsp_valid", 32'(rsp_valid),  32'd1);
        chk("rmwerr_rsp_error", 32'(rsp_error),  32'd1);
        chk("rmwerr_rsp_to",    32'(rsp_timeout), 32'd0);
        chk("rmwerr_rsp_rdata", rsp_rdata,       32'h77);
        tick();

        // Responder never ready: valid for exactly 4 cycles, then timeout
        rsp.ready = 1'b0;
        rsp.rdata = 32'hDEAD;
        send(2'd0, 13'h0004, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_valid_held", 32'(req.valid), 32'd1);
            tick();
        end
        chk("to_valid_dropped", 32'(req.valid),   32'd0);
        chk("to_rsp_valid",     32'(rsp_valid),   32'd1);
        chk("to_rsp_error",     32'(rsp_error),   32'd1);
        chk("to_rsp_timeout",   32'(rsp_timeout), 32'd1);
        chk("to_rsp_rdata",     rsp_rdata,        32'd0);
        tick();
        rsp.ready = 1'b1;
        rsp.rdata = 32'h11;
        send(2'd0, 13'h0008, 32'h0, 32'h0);
        tick();
        chk("after_to_rsp_rdata", rsp_rdata, 32'h11);
        tick();

        // Ready arriving exactly at the threshold cycle completes normally
        rsp.ready = 1'b0;
        rsp.rdata = 32'h3C;
        send(2'd0, 13'h0010, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        rsp.ready = 1'b1;
        tick();
        chk("thr_rsp_valid",   32'(rsp_valid),   32'd1);
        chk("thr_rsp_error",   32'(rsp_error),   32'd0);
        chk("thr_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("thr_rsp_rdata",   rsp_rdata,        32'h3C);
        tick();

        // Illegal op 3: immediate error response, no bus access
        send(2'd3, 13'h0000, 32'h0, 32'h0);
        chk("ill_req_valid", 32'(req.valid), 32'd0);
        chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ill_rsp_error", 32'(rsp_error), 32'd1);
        chk("ill_rsp_rdata", rsp_rdata,      32'd0);
        tick();

        // Response back-pressure for 5 cycles
        rsp_ready = 1'b0;
        rsp.rdata = 32'h1234;
        send(2'd0, 13'h0014, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata,      32'h1234);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset asserted mid-RD
        rsp.ready = 1'b0;
        send(2'd0, 13'h0018, 32'h0, 32'h0);
        chk("mid_rd_valid", 32'(req.valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_dropped", 32'(req.valid), 32'd0);
        chk("mid_rst_busy",        32'(busy),      32'd0);
        tick();
        rst_n = 1'b1;
        rsp.ready = 1'b1;
        tick();
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mid_rst_no_req", 32'(req.valid), 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
